pipe_mdu_ctrl: RTL and testbench

- Sequencer for a multi-cycle multiply/divide unit beside the decode stage of the 5-stage pipeline.
- Accepts MULT/MULTU/DIV/DIVU issued from ID using the forwarded operands (da/db), then runs a 32-iteration shift-add or restoring-divide loop.
- Owns the HI/LO registers and serves MFHI/MFLO/MTHI/MTLO.
- Raises a stall that the decode control ANDs into wpcir, so ID holds any HI/LO-touching instruction while the unit is busy.

---
 rtl/pipe_mdu_ctrl.sv | 174 +++++++++++++++++
 tb/tb_pipe_mdu_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_mdu_ctrl.sv
// Multi-cycle MULT/DIV sequencer beside ID; owns HI/LO and serves MFHI/MFLO/MTHI/MTLO.
// Result on hi/lo 34 cycles after issue; mdstall holds any HI/LO-touching op in ID while busy.
module pipe_mdu_ctrl #(
  parameter int ITER = 32
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [3:0]  dmdop,
  input  logic        dissue,
  input  logic [31:0] da,
  input  logic [31:0] db,
  output logic        mdstall,
  output logic        mdbusy,
  output logic [31:0] mdout,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        div_q, div_d;
  logic        neg_q, neg_d;
  logic        sa_q, sa_d;
  logic        dz_q, dz_d;
  logic [31:0] orig_a_q, orig_a_d;
  logic [31:0] opb_q, opb_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [63:0] acc_q, acc_d;
  logic [32:0] rem_q, rem_d;

  logic        is_md, is_hilo, is_signed, start;
  logic [31:0] mag_a, mag_b;
  logic [32:0] msum;
  logic [33:0] dshift, ddiff;
  logic        dge;
  logic [63:0] prod;
  logic [31:0] quo, rmd;

  assign is_md     = (dmdop >= OP_MULT) && (dmdop <= OP_DIVU);
  assign is_hilo   = (dmdop >= OP_MULT) && (dmdop <= OP_MTLO);
  assign is_signed = (dmdop == OP_MULT) || (dmdop == OP_DIV);
  assign mdbusy    = (state_q != IDLE);
  assign mdstall   = mdbusy && is_hilo;
  assign start     = dissue && !mdstall && is_md && (state_q == IDLE);

  assign mag_a = (is_signed && da[31]) ? 32'd0 - da : da;
  assign mag_b = (is_signed && db[31]) ? 32'd0 - db : db;

  // acc_q is {partial product, remaining multiplier bits} for multiply,
  // and holds dividend/quotient bits in its low half for divide.
  always_comb begin
    msum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
    dshift = {rem_q, acc_q[31]};
    ddiff  = dshift - {2'b00, opb_q};
    dge    = ~ddiff[33];
    prod   = neg_q ? 64'd0 - acc_q : acc_q;
    quo    = neg_q ? 32'd0 - acc_q[31:0] : acc_q[31:0];
    rmd    = sa_q ? 32'd0 - rem_q[31:0] : rem_q[31:0];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    neg_d    = neg_q;
    sa_d     = sa_q;
    dz_d     = dz_q;
    orig_a_d = orig_a_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          cnt_d    = 5'd0;
          div_d    = (dmdop == OP_DIV) || (dmdop == OP_DIVU);
          neg_d    = is_signed && (da[31] ^ db[31]);
          sa_d     = is_signed && da[31];
          dz_d     = (db == 32'd0);
          orig_a_d = da;
          opb_d    = mag_b;
          acc_d    = {32'd0, mag_a};
          rem_d    = 33'd0;
        end else if (dissue && (dmdop == OP_MTHI)) begin
          hi_d = da;
        end else if (dissue && (dmdop == OP_MTLO)) begin
          lo_d = da;
        end
      end
      RUN: begin
        cnt_d = cnt_q + 5'd1;
        if (div_q) begin
          rem_d = dge ? ddiff[32:0] : dshift[32:0];
          acc_d = {acc_q[63:32], acc_q[30:0], dge};
        end else begin
          acc_d = {msum, acc_q[31:1]};
        end
        if (cnt_q == 5'(ITER - 1)) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        cnt_d   = 5'd0;
        if (div_q) begin
          // Divide by zero bypasses the sign fix-up entirely.
          if (dz_q) begin
            lo_d = 32'hFFFF_FFFF;
            hi_d = orig_a_q;
          end else begin
            lo_d = quo;
            hi_d = rmd;
          end
        end else begin
          hi_d = prod[63:32];
          lo_d = prod[31:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q    <= 5'd0;
      div_q    <= 1'b0;
      neg_q    <= 1'b0;
      sa_q     <= 1'b0;
      dz_q     <= 1'b0;
      orig_a_q <= 32'd0;
      opb_q    <= 32'd0;
      acc_q    <= 64'd0;
      rem_q    <= 33'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      neg_q    <= neg_d;
      sa_q     <= sa_d;
      dz_q     <= dz_d;
      orig_a_q <= orig_a_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign mdout = (dmdop == OP_MFHI) ? hi_q :
                 (dmdop == OP_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_pipe_mdu_ctrl.sv
// Bench for pipe_mdu_ctrl: fixed vectors, hazard/reset sequences, and random ops against a model.
module tb_pipe_mdu_ctrl;

  logic        clock = 1'b0;
  logic        resetn;
  logic [3:0]  dmdop;
  logic        dissue;
  logic [31:0] da, db;
  logic        mdstall, mdbusy;
  logic [31:0] mdout, hi, lo;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  pipe_mdu_ctrl dut (
    .clock  (clock),
    .resetn (resetn),
    .dmdop  (dmdop),
    .dissue (dissue),
    .da     (da),
    .db     (db),
    .mdstall(mdstall),
    .mdbusy (mdbusy),
    .mdout  (mdout),
    .hi     (hi),
    .lo     (lo)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV division truncates toward zero,
  // remainder takes the dividend's sign.
  function automatic logic [63:0] ref_md(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, q, r, p;
    logic [63:0] res;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    res = 64'd0;
    case (op)
      4'd1: begin p = sa * sb; res = 64'(p); end
      4'd2: res = {32'd0, a} * {32'd0, b};
      4'd3: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      4'd4: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else res = {a % b, a / b};
      end
      default: res = 64'd0;
    endcase
    return res;
  endfunction

  // Issues one MD op, then counts busy cycles until idle (bounded).
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int busy);
    @(negedge clock);
    dmdop = op; dissue = 1'b1; da = a; db = b;
    #1;
    check("issue_no_stall", 32'(mdstall), 32'd0);
    @(posedge clock);
    #1;
    dmdop = 4'd0; dissue = 1'b0; da = $urandom; db = $urandom;
    busy = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (!mdbusy) break;
      busy++;
    end
  endtask

  task automatic write_hilo(input logic [3:0] op, input logic [31:0] a);
    @(negedge clock);
    dmdop = op; dissue = 1'b1; da = a;
    @(posedge clock);
    #1;
    dissue = 1'b0; dmdop = 4'd0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        vecs[9];
    int          busy, cnt;
    logic [3:0]  op;
    logic [31:0] a, b, m_hi, m_lo;
    logic [63:0] r;

    vecs[0] = '{4'd1, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[1] = '{4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2] = '{4'd3, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{4'd4, 32'd100,       32'd0,        32'd100,       32'hFFFF_FFFF};
    vecs[4] = '{4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000};
    vecs[5] = '{4'd3, 32'd7,         32'd0,        32'd7,         32'hFFFF_FFFF};
    vecs[6] = '{4'd4, 32'd100,       32'd7,        32'd2,         32'd14};
    vecs[7] = '{4'd3, 32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD};
    vecs[8] = '{4'd1, 32'd5,         32'd6,        32'd0,         32'd30};

    // Reset state
    resetn = 1'b0; dmdop = 4'd1; dissue = 1'b1; da = 32'h1234; db = 32'h5678;
    #12;
    check("rst_mdstall", 32'(mdstall), 32'd0);
    check("rst_mdbusy", 32'(mdbusy), 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    dmdop = 4'd5; #1;
    check("rst_mdout", mdout, 32'd0);
    @(negedge clock);
    resetn = 1'b1; dissue = 1'b0; dmdop = 4'd0;

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, busy);
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'd33);
      check($sformatf("vec%0d_hi", i), hi, vecs[i].exp_hi);
      check($sformatf("vec%0d_lo", i), lo, vecs[i].exp_lo);
    end

    // Dependent MFLO right behind a DIV
    @(negedge clock);
    dmdop = 4'd3; dissue = 1'b1; da = 32'hFFFF_FFF9; db = 32'd2;
    @(posedge clock); #1;
    dmdop = 4'd6; dissue = 1'b1; da = 32'd0; db = 32'd0;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (!mdstall) break;
      cnt++;
    end
    check("mflo_stall_cycles", 32'(cnt), 32'd33);
    check("mflo_mdout", mdout, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);
    dmdop = 4'd5; #1;
    check("mfhi_mdout", mdout, 32'hFFFF_FFFF);
    dissue = 1'b0; dmdop = 4'd0;

    // Busy-time stall decode, then MTLO held until FIX completes
    @(negedge clock);
    dmdop = 4'd2; dissue = 1'b1; da = 32'h0001_0000; db = 32'h0003_0000;
    @(posedge clock); #1;
    dmdop = 4'd0; dissue = 1'b1;
    @(negedge clock);
    check("busy_op0_stall", 32'(mdstall), 32'd0);
    check("busy_flag", 32'(mdbusy), 32'd1);
    dmdop = 4'd13; #1;
    check("busy_op13_stall", 32'(mdstall), 32'd0);
    dmdop = 4'd7; #1;
    check("busy_mthi_stall", 32'(mdstall), 32'd1);
    dmdop = 4'd8; da = 32'hCAFE_BABE; #1;
    check("busy_mtlo_stall", 32'(mdstall), 32'd1);
    repeat (10) @(negedge clock);
    check("busy_lo_held", lo, 32'hFFFF_FFFD);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (!mdstall) break;
      @(negedge clock);
      cnt++;
    end
    check("mtlo_wait_bounded", 32'(cnt < 100), 32'd1);
    check("mult_done_hi", hi, 32'd3);
    check("mult_done_lo", lo, 32'd0);
    @(posedge clock); #1;
    dissue = 1'b0; dmdop = 4'd0;
    check("mtlo_after_fix", lo, 32'hCAFE_BABE);
    check("mtlo_hi_kept", hi, 32'd3);

    // MTHI idle; dissue=0 suppresses writes and starts
    write_hilo(4'd7, 32'h1234_5678);
    check("mthi_idle", hi, 32'h1234_5678);
    @(negedge clock);
    dmdop = 4'd8; dissue = 1'b0; da = 32'h1;
    @(posedge clock); #1;
    check("mtlo_noissue", lo, 32'hCAFE_BABE);
    dmdop = 4'd1;
    @(posedge clock); #1;
    check("mult_noissue_busy", 32'(mdbusy), 32'd0);
    dmdop = 4'd0;

    // Reset during iteration 15 of a MULT
    @(negedge clock);
    dmdop = 4'd1; dissue = 1'b1; da = 32'hFFFF_FFFD; db = 32'd7;
    @(posedge clock); #1;
    dmdop = 4'd0; dissue = 1'b0;
    repeat (15) @(negedge clock);
    check("pre_rst_busy", 32'(mdbusy), 32'd1);
    #1 resetn = 1'b0;
    #1;
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    check("midrst_busy", 32'(mdbusy), 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    run_op(4'd1, 32'd5, 32'd6, busy);
    check("postrst_busy", 32'(busy), 32'd33);
    check("postrst_hi", hi, 32'd0);
    check("postrst_lo", lo, 32'd30);
    m_hi = 32'd0; m_lo = 32'd30;

    // Random ops against the model
    for (int n = 0; n < 30; n++) begin
      op = 4'($urandom_range(1, 8));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 5) == 0) b = 32'd0;
      else if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 15));
      if (op <= 4'd4) begin
        run_op(op, a, b, busy);
        r = ref_md(op, a, b);
        m_hi = r[63:32]; m_lo = r[31:0];
        check($sformatf("rnd%0d_op%0d_busy", n, op), 32'(busy), 32'd33);
        check($sformatf("rnd%0d_op%0d_hi", n, op), hi, m_hi);
        check($sformatf("rnd%0d_op%0d_lo", n, op), lo, m_lo);
      end else if (op <= 4'd6) begin
        @(negedge clock);
        dmdop = op; dissue = 1'b1; #1;
        check($sformatf("rnd%0d_mf", n), mdout, (op == 4'd5) ? m_hi : m_lo);
        @(posedge clock); #1;
        dissue = 1'b0; dmdop = 4'd0;
      end else begin
        write_hilo(op, a);
        if (op == 4'd7) m_hi = a; else m_lo = a;
        check($sformatf("rnd%0d_mt_hi", n), hi, m_hi);
        check($sformatf("rnd%0d_mt_lo", n), lo, m_lo);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
